// File: rtl/lfclk_monitor.sv
// -----------------------------------------------------------------------------
// lfclk_monitor
//   Receive side of the always-on low-frequency clock. lf_in (nominally clk/256)
//   is sampled as asynchronous data, rising edges become one-cycle ticks, the
//   rise-to-rise period is measured in clk cycles and judged against the
//   expected value, and a small state machine reports lock / loss so the AON
//   logic knows when its timebase can be trusted.
//
// Ports
//   clk          in   1      system clock, all logic on posedge
//   reset_n      in   1      asynchronous active-low reset
//   lf_in        in   1      low-frequency clock (asynchronous data)
//   lf_tick      out  1      one-cycle pulse per detected rising edge of lf_in
//   lf_period    out  CNT_W  last measured period in clk cycles
//   period_valid out  1      one-cycle pulse when lf_period updates
//   locked       out  1      high while locked to a good period
//   lost         out  1      high after the source stalled
//   err_cnt      out  8      saturating count of bad periods plus timeouts
// -----------------------------------------------------------------------------
module lfclk_monitor #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 10,
   parameter int EXP_PERIOD  = 256,
   parameter int TOL         = 4,
   parameter int LOCK_CNT    = 4,
   parameter int TIMEOUT     = 1023
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             lf_in,
   output logic             lf_tick,
   output logic [CNT_W-1:0] lf_period,
   output logic             period_valid,
   output logic             locked,
   output logic             lost,
   output logic [7:0]       err_cnt
);

   localparam logic [CNT_W:0]   PER_MIN   = (CNT_W+1)'(EXP_PERIOD - TOL);
   localparam logic [CNT_W:0]   PER_MAX   = (CNT_W+1)'(EXP_PERIOD + TOL);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [3:0]       LOCK_C    = 4'(LOCK_CNT);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOCKING = 2'd1,
      LOCKED  = 2'd2,
      LOST    = 2'd3
   } state_t;

   state_t                 state;
   state_t                 state_next;
   logic [SYNC_STAGES-1:0] sync;
   logic                   prev;
   logic                   rise;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W:0]         period;
   logic                   period_good;
   logic                   timeout;
   logic [3:0]             good_cnt;
   logic [3:0]             good_cnt_next;
   logic                   report;
   logic                   err_inc;

   // Synchronizer: lf_in enters at bit 0 and leaves from the top bit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync <= '0;
         prev <= 1'b0;
      end else begin
         if (SYNC_STAGES > 1)
            sync <= {sync[SYNC_STAGES-2:0], lf_in};
         else
            sync[0] <= lf_in;
         prev <= sync[SYNC_STAGES-1];
      end
   end

   assign rise = sync[SYNC_STAGES-1] & ~prev;

   // Period is one more than the count because cnt restarts at 0 in the cycle
   // after the edge. One extra bit keeps the saturated value (TIMEOUT+1) exact.
   assign period      = {1'b0, cnt} + (CNT_W+1)'(1);
   assign period_good = (period >= PER_MIN) && (period <= PER_MAX);
   // cnt sticks at TIMEOUT, but LOST ignores it, so each stall fires once.
   assign timeout     = (cnt == TIMEOUT_C);

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state logic; a rise always takes priority over a timeout.
   always_comb begin
      state_next    = state;
      good_cnt_next = good_cnt;
      report        = 1'b0;
      err_inc       = 1'b0;
      case (state)
         IDLE: begin
            if (rise) begin
               state_next    = LOCKING;
               good_cnt_next = 4'd0;
            end else if (timeout) begin
               state_next = LOST;
            end
         end
         LOCKING: begin
            if (rise) begin
               report = 1'b1;
               if (period_good) begin
                  if (good_cnt + 4'd1 == LOCK_C) begin
                     state_next    = LOCKED;
                     good_cnt_next = 4'd0;
                  end else begin
                     good_cnt_next = good_cnt + 4'd1;
                  end
               end else begin
                  good_cnt_next = 4'd0;
                  err_inc       = 1'b1;
               end
            end else if (timeout) begin
               state_next = LOST;
               err_inc    = 1'b1;
            end
         end
         LOCKED: begin
            if (rise) begin
               report = 1'b1;
               if (!period_good) begin
                  state_next    = LOCKING;
                  good_cnt_next = 4'd0;
                  err_inc       = 1'b1;
               end
            end else if (timeout) begin
               state_next = LOST;
               err_inc    = 1'b1;
            end
         end
         LOST: begin
            // The first edge after a stall carries no usable period.
            if (rise) begin
               state_next    = LOCKING;
               good_cnt_next = 4'd0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Status outputs decode directly from the state so reset clears them at once.
   always_comb begin
      locked = (state == LOCKED);
      lost   = (state == LOST);
   end

   // Datapath: counter, tick, period report and error counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt          <= '0;
         lf_tick      <= 1'b0;
         lf_period    <= '0;
         period_valid <= 1'b0;
         err_cnt      <= 8'd0;
         good_cnt     <= 4'd0;
      end else begin
         if (rise)
            cnt <= '0;
         else if (cnt != TIMEOUT_C)
            cnt <= cnt + 1'b1;
         lf_tick      <= rise;
         period_valid <= report;
         good_cnt     <= good_cnt_next;
         // A saturated period (TIMEOUT+1) does not fit CNT_W bits; the port
         // carries its low bits and the period has already been judged bad.
         if (report)
            lf_period <= period[CNT_W-1:0];
         if (err_inc && (err_cnt != 8'hFF))
            err_cnt <= err_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_lfclk_monitor.sv
// -----------------------------------------------------------------------------
// tb_lfclk_monitor
//   Drives lf_in as a sequence of randomized square-wave periods and stalls and
//   compares every clk cycle against an event-level model: each lf_in rise
//   produces a tick three cycles later, the period is the distance between
//   ticks, and timeouts happen when no tick follows within TIMEOUT+1 cycles.
// -----------------------------------------------------------------------------
module tb_lfclk_monitor;

   localparam int CNT_W   = 10;
   localparam int EXP     = 256;
   localparam int TOL     = 4;
   localparam int LOCKN   = 4;
   localparam int TMO     = 1023;
   localparam int LATENCY = 3;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             lf_in = 1'b0;
   logic             lf_tick;
   logic [CNT_W-1:0] lf_period;
   logic             period_valid;
   logic             locked;
   logic             lost;
   logic [7:0]       err_cnt;

   lfclk_monitor #(
      .SYNC_STAGES(2), .CNT_W(CNT_W), .EXP_PERIOD(EXP),
      .TOL(TOL), .LOCK_CNT(LOCKN), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .reset_n(reset_n), .lf_in(lf_in), .lf_tick(lf_tick),
      .lf_period(lf_period), .period_valid(period_valid), .locked(locked),
      .lost(lost), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Model: 0 idle, 1 locking, 2 locked, 3 lost.
   int cyc;
   int last_tick;
   int st;
   int good;
   int err;
   int lfp;
   int tick_q[$];
   bit lf_prev;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s at cyc %0d: observed %0d expected %0d", tag, cyc, got, exp);
      end
   endtask

   task automatic rst_pulse();
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      lf_in   = 1'b0;
      lf_prev = 1'b0;
      #1;
      chk("rst_locked", 32'(locked), 0);
      chk("rst_lost", 32'(lost), 0);
      chk("rst_tick", 32'(lf_tick), 0);
      chk("rst_pv", 32'(period_valid), 0);
      chk("rst_lf_period", 32'(lf_period), 0);
      chk("rst_err_cnt", 32'(err_cnt), 0);
      repeat (3) @(posedge clk);
      #1;
      reset_n   = 1'b1;
      cyc       = 0;
      last_tick = 0;
      st        = 0;
      good      = 0;
      err       = 0;
      lfp       = 0;
      tick_q.delete();
   endtask

   task automatic step(input logic v);
      bit tk;
      int pv;
      int per;
      @(posedge clk);
      #1;
      lf_in = v;
      cyc++;
      if (v && !lf_prev)
         tick_q.push_back(cyc + LATENCY);
      lf_prev = v;
      @(negedge clk);
      tk = (tick_q.size() > 0) && (tick_q[0] == cyc);
      if (tk)
         void'(tick_q.pop_front());
      pv = 0;
      if (tk) begin
         per = cyc - last_tick;
         if (per > TMO + 1)
            per = TMO + 1;
         if (st == 0 || st == 3) begin
            st   = 1;
            good = 0;
         end else begin
            pv  = 1;
            lfp = per % (1 << CNT_W);
            if (per >= EXP - TOL && per <= EXP + TOL) begin
               if (st == 1) begin
                  good++;
                  if (good == LOCKN) begin
                     st   = 2;
                     good = 0;
                  end
               end
            end else begin
               st   = 1;
               good = 0;
               if (err < 255) err++;
            end
         end
         last_tick = cyc;
         $display("tick cyc=%0d period=%0d state=%0d err=%0d", cyc, per, st, err);
      end else if ((cyc - last_tick == TMO + 1) && st != 3) begin
         if (st == 1 || st == 2) begin
            if (err < 255) err++;
         end
         st = 3;
         $display("timeout cyc=%0d err=%0d", cyc, err);
      end
      chk("lf_tick", 32'(lf_tick), 32'(tk));
      chk("period_valid", 32'(period_valid), 32'(pv));
      chk("lf_period", 32'(lf_period), 32'(lfp));
      chk("locked", 32'(locked), 32'(st == 2));
      chk("lost", 32'(lost), 32'(st == 3));
      chk("err_cnt", 32'(err_cnt), 32'(err));
   endtask

   // One lf_in period of p clk cycles with a random duty cycle (p >= 4).
   task automatic wave(input int p);
      int hi;
      hi = int'($urandom_range(2, p - 2));
      repeat (hi) step(1'b1);
      repeat (p - hi) step(1'b0);
   endtask

   task automatic stall(input int n);
      repeat (n) step(1'b0);
   endtask

   initial begin
      int pick;
      rst_pulse();
      stall(20);
      // Nominal wave: lock on the fifth edge.
      repeat (7) wave(EXP);
      // One long period drops lock; four good periods restore it.
      wave(300);
      repeat (6) wave(EXP);
      // Edge arriving exactly when the counter saturates: rise wins, bad period.
      wave(TMO + 1);
      repeat (6) wave(EXP);
      // Stall: lost after the counter saturates, recover afterwards.
      stall(1200);
      repeat (7) wave(EXP);
      // Tolerance boundaries.
      wave(252); wave(260); wave(251); wave(261); wave(256);
      repeat (6) wave(EXP);
      // Reset in the middle of lock, then relock.
      rst_pulse();
      stall(7);
      repeat (7) wave(EXP);
      // Random mix of good, bad and stalled periods.
      repeat (40) begin
         pick = int'($urandom_range(0, 9));
         if (pick < 6)
            wave(int'($urandom_range(EXP - TOL, EXP + TOL)));
         else if (pick < 8)
            wave(int'($urandom_range(180, 340)));
         else if (pick == 8)
            wave(int'($urandom_range(TMO - 1, TMO + 3)));
         else
            stall(int'($urandom_range(900, 1100)));
      end
      // Many short periods saturate the error counter.
      repeat (270) wave(8);
      repeat (7) wave(EXP);
      stall(10);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
